lsu_mem_access: RTL and testbench

- Executes the memory operation named by the decoder's `mem_opcode`: it is the responder for the decoder's memory-command interface.
- Takes one load/store request per handshake and runs a single-beat transaction on a 32-bit word-addressed data bus.
- Stores: forms byte strobes and replicated write data. Loads: extracts the byte/half/word lane, extends it, and returns it for register writeback.
- Sits between execute (address from ALU, store data from rs2) and the register-file writeback port.

---
 rtl/lsu_mem_access_pkg.sv | 38 +++
 rtl/lsu_lane_align.sv | 58 +++++
 rtl/lsu_mem_access.sv | 144 ++++++++++++++
 tb/tb_lsu_mem_access.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_access_pkg.sv
// Shared constants, opcode layout and helpers for the load/store unit and its lane aligner.
package lsu_mem_access_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned RD_W   = 5;

  localparam logic [2:0] MEM_DO_NOTHING = 3'b011;
  localparam logic [2:0] MEM_LB         = 3'b100;
  localparam logic [2:0] MEM_LH         = 3'b101;
  localparam logic [2:0] MEM_LW         = 3'b110;
  localparam logic [2:0] MEM_SB         = 3'b000;
  localparam logic [2:0] MEM_SH         = 3'b001;
  localparam logic [2:0] MEM_SW         = 3'b010;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam logic [1:0] LSU_IDLE = 2'd0;
  localparam logic [1:0] LSU_REQ  = 2'd1;
  localparam logic [1:0] LSU_WAIT = 2'd2;

  typedef struct packed {
    logic       is_load;
    logic [1:0] size;
  } mem_op_t;

  // Size 2'b11 is the no-op slot for stores and reserved for loads; both do nothing.
  function automatic logic is_mem_op(input mem_op_t op);
    return op.size != 2'b11;
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == SIZE_H) && addr_lo[0]) || ((size == SIZE_W) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane formatting: store strobe/data replication and load lane extraction with extension.
module lsu_lane_align
  import lsu_mem_access_pkg::*;
(
  input  logic [1:0]        i_st_size,
  input  logic [1:0]        i_st_addr_lo,
  input  logic [DATA_W-1:0] i_st_wdata,
  output logic [STRB_W-1:0] o_st_wstrb_c,
  output logic [DATA_W-1:0] o_st_wdata_c,
  input  logic [1:0]        i_ld_size,
  input  logic              i_ld_unsigned,
  input  logic [1:0]        i_ld_addr_lo,
  input  logic [DATA_W-1:0] i_ld_rdata,
  output logic [DATA_W-1:0] o_ld_data_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_st_wstrb_c = 4'b1111;
    o_st_wdata_c = i_st_wdata;
    case (i_st_size)
      SIZE_B: begin
        o_st_wstrb_c = 4'b0001 << i_st_addr_lo;
        o_st_wdata_c = {4{i_st_wdata[7:0]}};
      end
      SIZE_H: begin
        o_st_wstrb_c = i_st_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_st_wdata_c = {2{i_st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_byte = i_ld_rdata[7:0];
    case (i_ld_addr_lo)
      2'd1:    w_byte = i_ld_rdata[15:8];
      2'd2:    w_byte = i_ld_rdata[23:16];
      2'd3:    w_byte = i_ld_rdata[31:24];
      default: w_byte = i_ld_rdata[7:0];
    endcase
  end

  assign w_half = i_ld_addr_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];

  // Word loads ignore the unsigned flag.
  always_comb begin
    o_ld_data_c = i_ld_rdata;
    case (i_ld_size)
      SIZE_B: o_ld_data_c = i_ld_unsigned ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SIZE_H: o_ld_data_c = i_ld_unsigned ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// Load/store unit: accepts one memory command per handshake and runs a single-beat bus transaction.
module lsu_mem_access
  import lsu_mem_access_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        mem_opcode,
  input  logic              mem_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [RD_W-1:0]   rd,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-3:0] bus_addr,
  output logic [STRB_W-1:0] bus_wstrb,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              wb_valid,
  output logic [RD_W-1:0]   wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              st_done,
  output logic              misaligned
);

  mem_op_t             w_op;
  logic                w_accept;
  logic                w_noop;
  logic                w_misal;
  logic                w_start;
  logic [STRB_W-1:0]   w_st_wstrb;
  logic [DATA_W-1:0]   w_st_wdata;
  logic [DATA_W-1:0]   w_ld_data;
  logic [1:0]          w_state_nxt;

  logic [1:0]          r_state;
  logic                r_is_load;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic [1:0]          r_addr_lo;
  logic [RD_W-1:0]     r_rd;
  logic                r_bus_we;
  logic [ADDR_W-3:0]   r_bus_addr;
  logic [STRB_W-1:0]   r_bus_wstrb;
  logic [DATA_W-1:0]   r_bus_wdata;
  logic                r_wb_valid;
  logic [RD_W-1:0]     r_wb_rd;
  logic [DATA_W-1:0]   r_wb_data;
  logic                r_st_done;
  logic                r_misaligned;

  assign w_op     = mem_op_t'(mem_opcode);
  assign w_accept = req_valid & req_ready;
  assign w_noop   = !is_mem_op(w_op);
  assign w_misal  = is_misaligned(w_op.size, addr[1:0]);
  assign w_start  = w_accept & !w_noop & !w_misal;

  lsu_lane_align u_lane_align (
    .i_st_size     (w_op.size),
    .i_st_addr_lo  (addr[1:0]),
    .i_st_wdata    (wdata),
    .o_st_wstrb_c  (w_st_wstrb),
    .o_st_wdata_c  (w_st_wdata),
    .i_ld_size     (r_size),
    .i_ld_unsigned (r_unsigned),
    .i_ld_addr_lo  (r_addr_lo),
    .i_ld_rdata    (bus_rdata),
    .o_ld_data_c   (w_ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LSU_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LSU_IDLE: if (w_start)    w_state_nxt = LSU_REQ;
      LSU_REQ:  if (bus_gnt)    w_state_nxt = r_is_load ? LSU_WAIT : LSU_IDLE;
      LSU_WAIT: if (bus_rvalid) w_state_nxt = LSU_IDLE;
      default:                  w_state_nxt = LSU_IDLE;
    endcase
  end

  // Request capture only happens in IDLE, so bus fields stay frozen through REQ until grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_load    <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_addr_lo    <= 2'b00;
      r_rd         <= '0;
      r_bus_we     <= 1'b0;
      r_bus_addr   <= '0;
      r_bus_wstrb  <= '0;
      r_bus_wdata  <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_rd      <= '0;
      r_wb_data    <= '0;
      r_st_done    <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_wb_valid   <= 1'b0;
      r_st_done    <= 1'b0;
      r_misaligned <= w_accept & !w_noop & w_misal;
      if (w_start) begin
        r_is_load   <= w_op.is_load;
        r_size      <= w_op.size;
        r_unsigned  <= mem_unsigned;
        r_addr_lo   <= addr[1:0];
        r_rd        <= rd;
        r_bus_we    <= !w_op.is_load;
        r_bus_addr  <= addr[ADDR_W-1:2];
        r_bus_wstrb <= w_op.is_load ? STRB_W'(0) : w_st_wstrb;
        r_bus_wdata <= w_st_wdata;
      end
      if ((r_state == LSU_REQ) && bus_gnt && !r_is_load) r_st_done <= 1'b1;
      if ((r_state == LSU_WAIT) && bus_rvalid) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= r_rd;
        r_wb_data  <= w_ld_data;
      end
    end
  end

  assign req_ready  = (r_state == LSU_IDLE);
  assign bus_req    = (r_state == LSU_REQ);
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_wstrb  = r_bus_wstrb;
  assign bus_wdata  = r_bus_wdata;
  assign wb_valid   = r_wb_valid;
  assign wb_rd      = r_wb_rd;
  assign wb_data    = r_wb_data;
  assign st_done    = r_st_done;
  assign misaligned = r_misaligned;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed self-checking bench for lsu_mem_access with hand-computed expected values.
module tb_lsu_mem_access;
  import lsu_mem_access_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  mem_opcode;
  logic        mem_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [4:0]  rd;
  logic        bus_req;
  logic        bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        st_done;
  logic        misaligned;

  int n_checks = 0;
  int n_errors = 0;

  lsu_mem_access #(.ADDR_W(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .mem_opcode   (mem_opcode),
    .mem_unsigned (mem_unsigned),
    .addr         (addr),
    .wdata        (wdata),
    .rd           (rd),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wstrb    (bus_wstrb),
    .bus_wdata    (bus_wdata),
    .bus_gnt      (bus_gnt),
    .bus_rvalid   (bus_rvalid),
    .bus_rdata    (bus_rdata),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .st_done      (st_done),
    .misaligned   (misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for a single edge (the accept edge, cycle 0); returns in cycle 1.
  task automatic issue(input logic [2:0] op, input logic uns, input logic [31:0] a,
                       input logic [31:0] d, input logic [4:0] r);
    mem_opcode   = op;
    mem_unsigned = uns;
    addr         = a;
    wdata        = d;
    rd           = r;
    req_valid    = 1'b1;
    tick();
    req_valid    = 1'b0;
  endtask

  task automatic run_store(input string tag, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] d, input logic [29:0] e_addr,
                           input logic [3:0] e_strb, input logic [31:0] e_wdata);
    issue(op, 1'b0, a, d, 5'd0);
    bus_gnt = 1'b1;
    chk({tag, ".bus_req"}, 32'(bus_req), 32'd1);
    chk({tag, ".bus_we"}, 32'(bus_we), 32'd1);
    chk({tag, ".bus_addr"}, 32'(bus_addr), 32'(e_addr));
    chk({tag, ".bus_wstrb"}, 32'(bus_wstrb), 32'(e_strb));
    chk({tag, ".bus_wdata"}, bus_wdata, e_wdata);
    tick();
    bus_gnt = 1'b0;
    chk({tag, ".st_done_c2"}, 32'(st_done), 32'd1);
    chk({tag, ".bus_req_c2"}, 32'(bus_req), 32'd0);
    chk({tag, ".ready_c2"}, 32'(req_ready), 32'd1);
    tick();
    chk({tag, ".st_done_c3"}, 32'(st_done), 32'd0);
  endtask

  // Grant in cycle 1, rvalid in cycle 2; returns in the wb_valid cycle (cycle 3).
  task automatic run_load(input string tag, input logic [2:0] op, input logic uns,
                          input logic [31:0] a, input logic [4:0] r, input logic [31:0] rdat,
                          input logic [29:0] e_addr, input logic [31:0] e_data);
    issue(op, uns, a, 32'h0, r);
    bus_gnt = 1'b1;
    chk({tag, ".bus_req"}, 32'(bus_req), 32'd1);
    chk({tag, ".bus_we"}, 32'(bus_we), 32'd0);
    chk({tag, ".bus_wstrb"}, 32'(bus_wstrb), 32'd0);
    chk({tag, ".bus_addr"}, 32'(bus_addr), 32'(e_addr));
    tick();
    bus_gnt = 1'b0;
    chk({tag, ".wait_req"}, 32'(bus_req), 32'd0);
    chk({tag, ".wait_wb"}, 32'(wb_valid), 32'd0);
    bus_rvalid = 1'b1;
    bus_rdata  = rdat;
    tick();
    bus_rvalid = 1'b0;
    chk({tag, ".wb_valid_c3"}, 32'(wb_valid), 32'd1);
    chk({tag, ".wb_data"}, wb_data, e_data);
    chk({tag, ".wb_rd"}, 32'(wb_rd), 32'(r));
    chk({tag, ".ready_c3"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    mem_opcode   = MEM_DO_NOTHING;
    mem_unsigned = 1'b0;
    addr         = 32'h0;
    wdata        = 32'h0;
    rd           = 5'd0;
    bus_gnt      = 1'b0;
    bus_rvalid   = 1'b0;
    bus_rdata    = 32'h0;
    repeat (3) tick();

    chk("rst.bus_req", 32'(bus_req), 32'd0);
    chk("rst.bus_wstrb", 32'(bus_wstrb), 32'd0);
    chk("rst.bus_addr", 32'(bus_addr), 32'd0);
    chk("rst.wb_data", wb_data, 32'd0);
    chk("rst.strobes", 32'({wb_valid, st_done, misaligned}), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst.ready", 32'(req_ready), 32'd1);

    // Stores
    run_store("sb", MEM_SB, 32'h0000_1003, 32'h0000_00AB, 30'h400, 4'b1000, 32'hABAB_ABAB);
    run_store("sh", MEM_SH, 32'h0000_0012, 32'h1234_BEEF, 30'h004, 4'b1100, 32'hBEEF_BEEF);
    run_store("sw", MEM_SW, 32'h0000_0020, 32'h1122_3344, 30'h008, 4'b1111, 32'h1122_3344);

    // LH with grant held off for three REQ cycles; rvalid during REQ must be ignored
    issue(MEM_LH, 1'b0, 32'h0000_2002, 32'h0, 5'd7);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      chk("lh.hold_req", 32'(bus_req), 32'd1);
      chk("lh.hold_addr", 32'(bus_addr), 32'h800);
      chk("lh.hold_we", 32'(bus_we), 32'd0);
      chk("lh.hold_wb", 32'(wb_valid), 32'd0);
      tick();
      bus_rvalid = 1'b0;
    end
    bus_gnt = 1'b1;
    chk("lh.gnt_req", 32'(bus_req), 32'd1);
    tick();
    bus_gnt = 1'b0;
    chk("lh.wait_req", 32'(bus_req), 32'd0);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h8001_1234;
    tick();
    bus_rvalid = 1'b0;
    chk("lh.wb_valid", 32'(wb_valid), 32'd1);
    chk("lh.wb_data", wb_data, 32'hFFFF_8001);
    chk("lh.wb_rd", 32'(wb_rd), 32'd7);
    tick();
    chk("lh.wb_pulse", 32'(wb_valid), 32'd0);

    // Byte loads, unsigned then signed, plus a low-half unsigned
    run_load("lbu", MEM_LB, 1'b1, 32'h0000_2001, 5'd9, 32'h0000_F000, 30'h800, 32'h0000_00F0);
    tick();
    run_load("lb", MEM_LB, 1'b0, 32'h0000_2001, 5'd10, 32'h0000_F000, 30'h800, 32'hFFFF_FFF0);
    tick();
    run_load("lhu", MEM_LH, 1'b1, 32'h0000_2000, 5'd11, 32'h5555_9ABC, 30'h800, 32'h0000_9ABC);
    tick();

    // Misaligned word
    issue(MEM_LW, 1'b0, 32'h0000_3002, 32'h0, 5'd1);
    chk("mis.pulse", 32'(misaligned), 32'd1);
    chk("mis.no_req", 32'(bus_req), 32'd0);
    chk("mis.ready", 32'(req_ready), 32'd1);
    tick();
    chk("mis.pulse_end", 32'(misaligned), 32'd0);
    chk("mis.no_req2", 32'(bus_req), 32'd0);

    // Misaligned half
    issue(MEM_SH, 1'b0, 32'h0000_0011, 32'h0, 5'd0);
    chk("mish.pulse", 32'(misaligned), 32'd1);
    chk("mish.no_req", 32'(bus_req), 32'd0);
    tick();

    // No-op
    issue(MEM_DO_NOTHING, 1'b0, 32'h0000_0003, 32'h0, 5'd2);
    chk("nop.strobes", 32'({wb_valid, st_done, misaligned}), 32'd0);
    chk("nop.no_req", 32'(bus_req), 32'd0);
    chk("nop.ready", 32'(req_ready), 32'd1);
    tick();
    chk("nop.strobes2", 32'({wb_valid, st_done, misaligned, bus_req}), 32'd0);

    // Back-to-back: second LW accepted in the wb_valid cycle of the first
    run_load("b2b1", MEM_LW, 1'b1, 32'h0000_0040, 5'd3, 32'h1234_5678, 30'h010, 32'h1234_5678);
    issue(MEM_LW, 1'b0, 32'h0000_0044, 32'h0, 5'd4);
    chk("b2b2.req", 32'(bus_req), 32'd1);
    chk("b2b2.addr", 32'(bus_addr), 32'h011);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hDEAD_0000;
    tick();
    bus_rvalid = 1'b0;
    chk("b2b2.rvalid_ignored", 32'(wb_valid), 32'd0);
    chk("b2b2.still_req", 32'(bus_req), 32'd1);
    bus_gnt = 1'b1;
    tick();
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hCAFE_F00D;
    tick();
    bus_rvalid = 1'b0;
    chk("b2b2.wb_valid", 32'(wb_valid), 32'd1);
    chk("b2b2.wb_data", wb_data, 32'hCAFE_F00D);
    chk("b2b2.wb_rd", 32'(wb_rd), 32'd4);
    tick();

    // Reset in REQ drops bus_req immediately
    issue(MEM_SW, 1'b0, 32'h0000_0060, 32'h0BAD_0BAD, 5'd0);
    chk("rreq.req", 32'(bus_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rreq.req_drop", 32'(bus_req), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rreq.no_st_done", 32'(st_done), 32'd0);

    // Reset in WAIT: no writeback, back to ready
    issue(MEM_LW, 1'b0, 32'h0000_0050, 32'h0, 5'd5);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chk("rwait.in_wait", 32'({bus_req, req_ready}), 32'd0);
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h7777_7777;
    rst_n = 1'b0;
    #1;
    chk("rwait.bus_req", 32'(bus_req), 32'd0);
    chk("rwait.wb_valid", 32'(wb_valid), 32'd0);
    tick();
    bus_rvalid = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("rwait.no_stale_wb", 32'(wb_valid), 32'd0);
    chk("rwait.ready", 32'(req_ready), 32'd1);
    chk("rwait.wb_data", wb_data, 32'd0);
    tick();
    chk("rwait.idle", 32'({wb_valid, bus_req}), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
